// File: rtl/arith_pkg.sv
// Shared constants and FSM state type for the serial arithmetic datapath.
// A nibble-serial unit walks NSLICE_DEF slices of SLICE_DEF bits each.
package arith_pkg;

  localparam int SLICE_DEF  = 4;
  localparam int WIDTH_DEF  = 16;
  localparam int NSLICE_DEF = WIDTH_DEF / SLICE_DEF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/nibble_subtractor_4_bit.sv
// Combinational slice computing A + ~B + Cin (two's-complement subtract).
// Cout=1 means the slice produced no borrow.
module nibble_subtractor_4_bit
  import arith_pkg::*;
#(
  parameter int W = SLICE_DEF
) (
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         Cin,
  output logic [W-1:0] Diff,
  output logic         Cout
);

  assign {Cout, Diff} = {1'b0, A} + {1'b0, ~B} + {{W{1'b0}}, Cin};

endmodule

// File: rtl/serial_subtractor_16_bit.sv
// Multi-cycle subtractor: Diff = A - B - Bin, one SLICE-bit slice per clock,
// LSB slice first, with the inter-slice carry held in a register.
module serial_subtractor_16_bit
  import arith_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int SLICE = SLICE_DEF
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Bin,
  output logic [WIDTH-1:0] Diff,
  output logic             Bout,
  output logic             Overflow,
  output logic             Busy,
  output logic             Done,
  output state_e           dbg_state_o
);

  localparam int NSL = WIDTH / SLICE;
  localparam int CW  = (NSL > 1) ? $clog2(NSL) : 1;
  localparam logic [CW-1:0] LAST = CW'(NSL - 1);

  // Handshake: Start is sampled only in IDLE; the edge that sees Start=1
  // captures A/B/Bin. Done is a one-cycle pulse, Busy covers RUN and DONE,
  // and Start outside IDLE is dropped rather than queued.

  state_e            state_q, state_d;
  logic [WIDTH-1:0]  a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0]  diff_q, diff_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              carry_q, carry_d;
  logic              bout_q, bout_d;
  logic              ovf_q, ovf_d;

  logic [SLICE-1:0]  a_slice, b_slice, s_slice;
  logic              s_cout;

  assign a_slice = a_q[int'(cnt_q)*SLICE +: SLICE];
  assign b_slice = b_q[int'(cnt_q)*SLICE +: SLICE];

  nibble_subtractor_4_bit #(.W(SLICE)) u_slice (
    .A    (a_slice),
    .B    (b_slice),
    .Cin  (carry_q),
    .Diff (s_slice),
    .Cout (s_cout)
  );

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      diff_q  <= '0;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      bout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      diff_q  <= diff_d;
      cnt_q   <= cnt_d;
      carry_q <= carry_d;
      bout_q  <= bout_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    diff_d  = diff_q;
    cnt_d   = cnt_q;
    carry_d = carry_q;
    bout_d  = bout_q;
    ovf_d   = ovf_q;
    case (state_q)
      IDLE: begin
        if (Start) begin
          a_d     = A;
          b_d     = B;
          carry_d = ~Bin;  // borrow-in folds into the +1 of two's complement
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        diff_d[int'(cnt_q)*SLICE +: SLICE] = s_slice;
        carry_d = s_cout;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST) begin
          bout_d  = ~s_cout;
          // s_slice MSB is the final Diff MSB on the last slice
          ovf_d   = (a_q[WIDTH-1] != b_q[WIDTH-1]) &&
                    (s_slice[SLICE-1] != a_q[WIDTH-1]);
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign Diff        = diff_q;
  assign Bout        = bout_q;
  assign Overflow    = ovf_q;
  assign Busy        = (state_q != IDLE);
  assign Done        = (state_q == DONE);
  assign dbg_state_o = state_q;

endmodule
